// File: rtl/rr_arb_pkg.sv
// Shared types and sizes for the eight-way round-robin arbiter.
package rr_arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned ID_W  = 3;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        return N_REQ'(1) << id;
    endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-to-3 priority encoder: index of the lowest set bit plus a valid flag.
module prio_enc8
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] vec_i,
    output logic [ID_W-1:0]  idx_o,
    output logic             valid_o
);

    // Scan from the top so the lowest set bit is written last and wins.
    always_comb begin
        idx_o = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = ID_W'(i);
            end
        end
    end

    assign valid_o = |vec_i;

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant and binary index.
// Define RR_ARB_TIMEOUT_EN to force a release after MAX_HOLD cycles of ownership.
module rr_arbiter8
    import rr_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
        $error("rr_arbiter8: MAX_HOLD must be within 2..256");
    end

    arb_state_t       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q, timeout_d;

    logic [2*N_REQ-1:0] req_dbl_c;
    logic [N_REQ-1:0]   req_rot_c;
    logic [ID_W-1:0]    enc_idx_c;
    logic               enc_valid_c;
    logic [ID_W-1:0]    winner_c;
    logic               owner_req_c;
    logic               expire_c;

    // Rotate right by ptr so the search starts at ptr; 3-bit add wraps mod 8.
    assign req_dbl_c = {req, req};
    assign req_rot_c = N_REQ'(req_dbl_c >> ptr_q);
    assign winner_c  = enc_idx_c + ptr_q;

    prio_enc8 u_enc (
        .vec_i   (req_rot_c),
        .idx_o   (enc_idx_c),
        .valid_o (enc_valid_c)
    );

    assign owner_req_c = req[gnt_id_q];

`ifdef RR_ARB_TIMEOUT_EN
    localparam int unsigned HOLD_W = 8;

    logic [HOLD_W-1:0] hold_q, hold_d;

    // A drop on the expiry cycle is an ordinary release, not a timeout.
    assign expire_c = owner_req_c && (hold_q == HOLD_W'(MAX_HOLD - 1));

    always_comb begin
        hold_d = '0;
        if (state_q == ARB_GRANT && owner_req_c && !expire_c) begin
            hold_d = hold_q + HOLD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign expire_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:  if (enc_valid_c) state_d = ARB_GRANT;
            ARB_GRANT: if (!owner_req_c || expire_c) state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    // Next values for the registered outputs and the priority pointer.
    always_comb begin
        gnt_d       = '0;
        gnt_id_d    = '0;
        gnt_valid_d = 1'b0;
        timeout_d   = 1'b0;
        ptr_d       = ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (enc_valid_c) begin
                    gnt_d       = id_to_onehot(winner_c);
                    gnt_id_d    = winner_c;
                    gnt_valid_d = 1'b1;
                    ptr_d       = winner_c + ID_W'(1);
                end
            end
            ARB_GRANT: begin
                if (owner_req_c && !expire_c) begin
                    gnt_d       = gnt_q;
                    gnt_id_d    = gnt_id_q;
                    gnt_valid_d = 1'b1;
                end else if (expire_c) begin
                    timeout_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed, table-driven bench for rr_arbiter8; hold-limit sequence depends on RR_ARB_TIMEOUT_EN.
module tb_rr_arbiter8;

    localparam int unsigned MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] id;
        logic       valid;
        logic       tmo;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    task automatic add(input logic r, input logic [7:0] q, input logic [7:0] g,
                       input logic [2:0] id, input logic v, input logic t);
        vec_t e;
        e.rst = r; e.req = q; e.gnt = g; e.id = id; e.valid = v; e.tmo = t;
        vecs.push_back(e);
    endtask

    task automatic add_grant(input logic r, input logic [7:0] q, input logic [2:0] id);
        logic [7:0] one;
        one = 8'h01;
        add(r, q, one << id, id, 1'b1, 1'b0);
    endtask

    task automatic add_idle(input logic r, input logic [7:0] q);
        add(r, q, 8'h00, 3'd0, 1'b0, 1'b0);
    endtask

    // Drive inputs, let one edge pass, sample 1 ns later and compare.
    task automatic apply_check(input string tag, input int idx, input logic r, input logic [7:0] q,
                               input logic [7:0] eg, input logic [2:0] eid, input logic ev, input logic et);
        rst = r;
        req = q;
        @(posedge clk);
        #1;
        n_cmp++;
        if (gnt !== eg || gnt_id !== eid || gnt_valid !== ev || timeout !== et) begin
            n_bad++;
            $display("FAIL %s[%0d]: got gnt=%h id=%0d valid=%b timeout=%b, want gnt=%h id=%0d valid=%b timeout=%b",
                     tag, idx, gnt, gnt_id, gnt_valid, timeout, eg, eid, ev, et);
        end
    endtask

    initial begin
        logic [7:0] one;
        one = 8'h01;
        rst = 1'b1;
        req = 8'h00;

        // Reset, then ten idle cycles.
        add_idle(1'b1, 8'h00);
        for (int i = 0; i < 10; i++) add_idle(1'b0, 8'h00);

        // All requesting: grants rotate 0..7,0 with one idle cycle between owners.
        for (int k = 0; k < 9; k++) begin
            logic [2:0] id;
            id = 3'(k % 8);
            for (int c = 0; c < 3; c++) add_grant(1'b0, 8'hFF, id);
            add_idle(1'b0, 8'hFF & ~(one << id));
        end

        // Grant to 4 leaves ptr=5; req=09 wraps to 0, then goes to 3.
        add_grant(1'b0, 8'h10, 3'd4);
        add_idle (1'b0, 8'h00);
        add_grant(1'b0, 8'h09, 3'd0);
        add_idle (1'b0, 8'h08);
        add_grant(1'b0, 8'h09, 3'd3);
        add_idle (1'b0, 8'h00);

        // Single requester 6 for four cycles; drop coincides with the 4th hold cycle.
        for (int c = 0; c < 4; c++) add_grant(1'b0, 8'h40, 3'd6);
        add_idle(1'b0, 8'h00);

        // ptr=7 picks 4 from 0x30; reset mid-grant restores ptr=0, so 4 wins again.
        add_grant(1'b0, 8'h30, 3'd4);
        add_idle (1'b1, 8'h30);
        add_grant(1'b0, 8'h30, 3'd4);
        add_grant(1'b0, 8'h30, 3'd4);
        add_idle (1'b0, 8'h20);
        add_grant(1'b0, 8'h20, 3'd5);
        add_idle (1'b0, 8'h00);

        foreach (vecs[i]) begin
            apply_check("vec", i, vecs[i].rst, vecs[i].req, vecs[i].gnt,
                        vecs[i].id, vecs[i].valid, vecs[i].tmo);
        end

`ifdef RR_ARB_TIMEOUT_EN
        // req[2] held: 4 grant cycles, 1 timeout/idle cycle, repeat.
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) apply_check("tmo_grant", r * 4 + c, 1'b0, 8'h04, 8'h04, 3'd2, 1'b1, 1'b0);
            apply_check("tmo_pulse", r, 1'b0, 8'h04, 8'h00, 3'd0, 1'b0, 1'b1);
        end
        // Drop on the expiry cycle: normal release, no pulse.
        for (int c = 0; c < 4; c++) apply_check("tmo_drop_grant", c, 1'b0, 8'h04, 8'h04, 3'd2, 1'b1, 1'b0);
        apply_check("tmo_drop_release", 0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
`else
        // Without the hold limit, a held request keeps its grant indefinitely.
        for (int c = 0; c < 20; c++) apply_check("hold", c, 1'b0, 8'h04, 8'h04, 3'd2, 1'b1, 1'b0);
        apply_check("hold_release", 0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
